// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encoding, default datapath width and the
// sequencer state type.
package alu_pkg;

    localparam int unsigned WIDTH = 16;

    typedef logic [2:0] alu_opc_t;

    localparam alu_opc_t OPC_ADDC = 3'd0;
    localparam alu_opc_t OPC_A2B  = 3'd1;
    localparam alu_opc_t OPC_INCB = 3'd2;
    localparam alu_opc_t OPC_B3   = 3'd3;
    localparam alu_opc_t OPC_AND  = 3'd4;
    localparam alu_opc_t OPC_OR   = 3'd5;
    localparam alu_opc_t OPC_NOTB = 3'd6;
    localparam alu_opc_t OPC_ZERO = 3'd7;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } seq_state_e;

endpackage

// File: rtl/alu_cmd_sequencer_if.sv
// Command and result handshake bundle between a command source/result sink
// (master) and the ALU command sequencer (slave).
interface alu_cmd_sequencer_if #(
    parameter int unsigned WIDTH = 16
) ();

    logic             cmd_valid;
    logic             cmd_ready;
    logic [2:0]       cmd_opc;
    logic [WIDTH-1:0] cmd_a;
    logic [WIDTH-1:0] cmd_b;
    logic             cmd_c;
    logic             cmd_use_acc;
    logic             cmd_acc_clr;

    logic             res_valid;
    logic             res_ready;
    logic [WIDTH-1:0] res_data;
    logic             res_zer;
    logic             res_neg;

    modport master (
        output cmd_valid, cmd_opc, cmd_a, cmd_b, cmd_c, cmd_use_acc, cmd_acc_clr, res_ready,
        input  cmd_ready, res_valid, res_data, res_zer, res_neg
    );

    modport slave (
        input  cmd_valid, cmd_opc, cmd_a, cmd_b, cmd_c, cmd_use_acc, cmd_acc_clr, res_ready,
        output cmd_ready, res_valid, res_data, res_zer, res_neg
    );

endinterface

// File: rtl/alu_cmd_seq_ctrl.sv
// Sequencer control: IDLE/EXEC/RESP FSM plus settle counter, emitting the
// load, accumulator-clear, capture and deliver strobes for the datapath.
module alu_cmd_seq_ctrl import alu_pkg::*; #(
    parameter int unsigned SETTLE_CYCLES = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic cmd_valid,
    input  logic cmd_acc_clr,
    input  logic res_ready,
    output logic cmd_ready,
    output logic res_valid,
    output logic load_op,
    output logic clr_acc,
    output logic capture,
    output logic deliver
);

    seq_state_e state_q, state_d;
    logic [3:0] cnt_q, cnt_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        cmd_ready = 1'b0;
        res_valid = 1'b0;
        load_op   = 1'b0;
        clr_acc   = 1'b0;
        capture   = 1'b0;
        deliver   = 1'b0;
        case (state_q)
            IDLE: begin
                // Held low during reset so nothing is accepted while the flops are cleared.
                cmd_ready = !rst;
                if (cmd_valid && cmd_ready) begin
                    if (cmd_acc_clr) begin
                        clr_acc = 1'b1;
                    end else begin
                        load_op = 1'b1;
                        cnt_d   = 4'(SETTLE_CYCLES - 1);
                        state_d = EXEC;
                    end
                end
            end
            EXEC: begin
                if (cnt_q == 4'd0) begin
                    capture = 1'b1;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                res_valid = 1'b1;
                if (res_ready) begin
                    deliver = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Command sequencer in front of the 16-bit ALU: registers operands, waits the
// settle time, captures W/flags and hands them downstream. Optional counters
// are enabled with the ALU_CMD_SEQ_STATS_EN macro.
module alu_cmd_sequencer import alu_pkg::*; #(
    parameter int unsigned WIDTH         = alu_pkg::WIDTH,
    parameter int unsigned SETTLE_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst,
    alu_cmd_sequencer_if.slave bus,
    output logic [WIDTH-1:0]  alu_a,
    output logic [WIDTH-1:0]  alu_b,
    output logic              alu_c,
    output logic [2:0]        alu_opc,
    input  logic [WIDTH-1:0]  alu_w,
    input  logic              alu_zer,
    input  logic              alu_neg,
    output logic [WIDTH-1:0]  acc_out
`ifdef ALU_CMD_SEQ_STATS_EN
    ,
    output logic [15:0]       stat_ops,
    output logic [15:0]       stat_zero
`endif
);

    logic load_op, clr_acc, capture, deliver;
    logic cmd_ready, res_valid;

    alu_cmd_seq_ctrl #(
        .SETTLE_CYCLES(SETTLE_CYCLES)
    ) u_ctrl (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (bus.cmd_valid),
        .cmd_acc_clr(bus.cmd_acc_clr),
        .res_ready  (bus.res_ready),
        .cmd_ready  (cmd_ready),
        .res_valid  (res_valid),
        .load_op    (load_op),
        .clr_acc    (clr_acc),
        .capture    (capture),
        .deliver    (deliver)
    );

    logic [WIDTH-1:0] alu_a_q, alu_b_q, res_data_q, acc_q;
    logic             alu_c_q, res_zer_q, res_neg_q;
    alu_opc_t         alu_opc_q;

    // ALU operands change only on an accepted command and are held afterwards.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_a_q    <= '0;
            alu_b_q    <= '0;
            alu_c_q    <= 1'b0;
            alu_opc_q  <= OPC_ADDC;
            res_data_q <= '0;
            res_zer_q  <= 1'b0;
            res_neg_q  <= 1'b0;
            acc_q      <= '0;
        end else begin
            if (load_op) begin
                alu_a_q   <= bus.cmd_use_acc ? acc_q : bus.cmd_a;
                alu_b_q   <= bus.cmd_b;
                alu_c_q   <= bus.cmd_c;
                alu_opc_q <= bus.cmd_opc;
            end
            if (capture) begin
                res_data_q <= alu_w;
                res_zer_q  <= alu_zer;
                res_neg_q  <= alu_neg;
            end
            if (clr_acc) begin
                acc_q <= '0;
            end else if (capture) begin
                acc_q <= alu_w;
            end
        end
    end

    assign alu_a   = alu_a_q;
    assign alu_b   = alu_b_q;
    assign alu_c   = alu_c_q;
    assign alu_opc = alu_opc_q;
    assign acc_out = acc_q;

    assign bus.cmd_ready = cmd_ready;
    assign bus.res_valid = res_valid;
    assign bus.res_data  = res_data_q;
    assign bus.res_zer   = res_zer_q;
    assign bus.res_neg   = res_neg_q;

`ifdef ALU_CMD_SEQ_STATS_EN
    logic [15:0] stat_ops_q, stat_zero_q;

    // Counted on the result handshake, so accumulator clears never contribute.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_ops_q  <= '0;
            stat_zero_q <= '0;
        end else if (deliver) begin
            if (stat_ops_q != 16'hFFFF) begin
                stat_ops_q <= stat_ops_q + 16'd1;
            end
            if (res_zer_q && (stat_zero_q != 16'hFFFF)) begin
                stat_zero_q <= stat_zero_q + 16'd1;
            end
        end
    end

    assign stat_ops  = stat_ops_q;
    assign stat_zero = stat_zero_q;
`endif

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Self-checking bench: behavioural ALU model behind each sequencer, scoreboard
// of expected results, one task per scenario.
module tb_alu_cmd_sequencer;
    import alu_pkg::*;

    localparam int unsigned W = 16;

    typedef struct packed {
        logic [W-1:0] data;
        logic         zer;
        logic         neg;
    } res_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [W-1:0] alu_fn(input logic [2:0] opc, input logic [W-1:0] a,
                                            input logic [W-1:0] b, input logic c);
        case (opc)
            OPC_ADDC: alu_fn = a + b + {{(W-1){1'b0}}, c};
            OPC_A2B:  alu_fn = a + (b << 1);
            OPC_INCB: alu_fn = b + 1'b1;
            OPC_B3:   alu_fn = b + (b << 1);
            OPC_AND:  alu_fn = a & b;
            OPC_OR:   alu_fn = a | b;
            OPC_NOTB: alu_fn = ~b;
            default:  alu_fn = '0;
        endcase
    endfunction

    // DUT with SETTLE_CYCLES=1
    alu_cmd_sequencer_if #(.WIDTH(W)) bus ();
    logic [W-1:0] alu_a, alu_b, alu_w, acc_out;
    logic         alu_c, alu_zer, alu_neg;
    logic [2:0]   alu_opc;
    assign alu_w   = alu_fn(alu_opc, alu_a, alu_b, alu_c);
    assign alu_zer = (alu_w == '0);
    assign alu_neg = alu_w[W-1];

    // DUT with SETTLE_CYCLES=4
    alu_cmd_sequencer_if #(.WIDTH(W)) bus4 ();
    logic [W-1:0] alu_a4, alu_b4, alu_w4, acc_out4;
    logic         alu_c4, alu_zer4, alu_neg4;
    logic [2:0]   alu_opc4;
    assign alu_w4   = alu_fn(alu_opc4, alu_a4, alu_b4, alu_c4);
    assign alu_zer4 = (alu_w4 == '0);
    assign alu_neg4 = alu_w4[W-1];

`ifdef ALU_CMD_SEQ_STATS_EN
    logic [15:0] stat_ops, stat_zero, stat_ops4, stat_zero4;
`endif

    alu_cmd_sequencer #(.WIDTH(W), .SETTLE_CYCLES(1)) dut (
        .clk(clk), .rst(rst), .bus(bus),
        .alu_a(alu_a), .alu_b(alu_b), .alu_c(alu_c), .alu_opc(alu_opc),
        .alu_w(alu_w), .alu_zer(alu_zer), .alu_neg(alu_neg), .acc_out(acc_out)
`ifdef ALU_CMD_SEQ_STATS_EN
        , .stat_ops(stat_ops), .stat_zero(stat_zero)
`endif
    );

    alu_cmd_sequencer #(.WIDTH(W), .SETTLE_CYCLES(4)) dut4 (
        .clk(clk), .rst(rst), .bus(bus4),
        .alu_a(alu_a4), .alu_b(alu_b4), .alu_c(alu_c4), .alu_opc(alu_opc4),
        .alu_w(alu_w4), .alu_zer(alu_zer4), .alu_neg(alu_neg4), .acc_out(acc_out4)
`ifdef ALU_CMD_SEQ_STATS_EN
        , .stat_ops(stat_ops4), .stat_zero(stat_zero4)
`endif
    );

    res_t         sb[$];
    logic [W-1:0] model_acc = '0;

    // Drive one command at the first negedge with cmd_ready=1; push its expectation.
    task automatic send_cmd(input logic [2:0] opc, input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic c, input logic use_acc, input logic clr,
                            output int acc_cyc);
        int n = 0;
        logic [W-1:0] w;
        while (bus.cmd_ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            n_checks++;
            n_fail++;
            $display("FAIL cmd_ready_timeout: cmd_ready=%b required 1", bus.cmd_ready);
        end
        bus.cmd_opc     = opc;
        bus.cmd_a       = a;
        bus.cmd_b       = b;
        bus.cmd_c       = c;
        bus.cmd_use_acc = use_acc;
        bus.cmd_acc_clr = clr;
        bus.cmd_valid   = 1'b1;
        acc_cyc         = cyc;
        if (clr) begin
            model_acc = '0;
        end else begin
            w = alu_fn(opc, use_acc ? model_acc : a, b, c);
            sb.push_back('{data: w, zer: (w == '0), neg: w[W-1]});
            model_acc = w;
        end
        @(negedge clk);
        bus.cmd_valid = 1'b0;
    endtask

    // Wait for res_valid; return observed result and the cycle it was first seen.
    task automatic get_res(output res_t r, output int rcyc);
        int n = 0;
        while (bus.res_valid !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            n_checks++;
            n_fail++;
            $display("FAIL res_valid_timeout: res_valid=%b required 1", bus.res_valid);
        end
        r    = '{data: bus.res_data, zer: bus.res_zer, neg: bus.res_neg};
        rcyc = cyc;
        if (bus.res_ready === 1'b1) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(negedge clk);
        n_checks++;
        if (bus.cmd_ready !== 1'b0) begin
            n_fail++; $display("FAIL reset_cmd_ready: got %b want 0", bus.cmd_ready);
        end
        n_checks++;
        if ({bus.res_valid, bus.res_data, acc_out, alu_a, alu_b} !== '0) begin
            n_fail++;
            $display("FAIL reset_regs: valid=%b data=%h acc=%h a=%h b=%h want all 0",
                     bus.res_valid, bus.res_data, acc_out, alu_a, alu_b);
        end
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (bus.cmd_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_release_ready: got %b want 1", bus.cmd_ready);
        end
    endtask

    task automatic test_addc();
        int ac, rc;
        res_t r, e;
        send_cmd(OPC_ADDC, 16'd5, 16'd3, 1'b1, 1'b0, 1'b0, ac);
        get_res(r, rc);
        e = sb.pop_front();
        n_checks++;
        if (r !== e || r.data !== 16'd9) begin
            n_fail++; $display("FAIL addc_result: got %h/%b/%b want %h/%b/%b (9)",
                               r.data, r.zer, r.neg, e.data, e.zer, e.neg);
        end
        n_checks++;
        if (rc - ac !== 2) begin
            n_fail++; $display("FAIL addc_latency: got %0d cycles want 2", rc - ac);
        end
        n_checks++;
        if (acc_out !== 16'd9 || bus.res_valid !== 1'b0) begin
            n_fail++; $display("FAIL addc_acc: acc=%h valid=%b want 0009/0", acc_out, bus.res_valid);
        end
    endtask

    task automatic test_chain();
        int ac, rc;
        res_t r, e;
        send_cmd(OPC_AND, 16'h00FF, 16'h0F0F, 1'b0, 1'b0, 1'b0, ac);
        get_res(r, rc);
        e = sb.pop_front();
        n_checks++;
        if (r !== e || r.data !== 16'h000F) begin
            n_fail++; $display("FAIL chain_and: got %h want %h (000f)", r.data, e.data);
        end
        send_cmd(OPC_OR, 16'h1234, 16'hF000, 1'b0, 1'b1, 1'b0, ac);
        get_res(r, rc);
        e = sb.pop_front();
        n_checks++;
        if (r !== e || r.data !== 16'hF00F || r.neg !== 1'b1) begin
            n_fail++; $display("FAIL chain_or_acc: got %h neg=%b want %h neg=1", r.data, r.neg, e.data);
        end
    endtask

    task automatic test_wrap();
        int ac, rc;
        res_t r, e;
        send_cmd(OPC_INCB, 16'h0000, 16'hFFFF, 1'b0, 1'b0, 1'b0, ac);
        get_res(r, rc);
        e = sb.pop_front();
        n_checks++;
        if (r !== e || r.data !== 16'h0000 || r.zer !== 1'b1) begin
            n_fail++; $display("FAIL wrap_incb: got %h zer=%b want 0000 zer=1", r.data, r.zer);
        end
        send_cmd(OPC_ZERO, 16'h1234, 16'h0005, 1'b1, 1'b0, 1'b0, ac);
        get_res(r, rc);
        e = sb.pop_front();
        n_checks++;
        if (r !== e || r.zer !== 1'b1) begin
            n_fail++; $display("FAIL zero_op: got %h zer=%b want 0000 zer=1", r.data, r.zer);
        end
    endtask

    task automatic test_backpressure();
        int ac, rc;
        res_t r, e;
        logic [W-1:0] snap_a;
        bus.res_ready = 1'b0;
        send_cmd(OPC_ADDC, 16'd100, 16'd200, 1'b0, 1'b0, 1'b0, ac);
        get_res(r, rc);
        snap_a = alu_a;
        // A competing command must not be taken while the result is pending.
        bus.cmd_valid = 1'b1;
        bus.cmd_a     = 16'hFFFF;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_checks++;
            if (bus.res_valid !== 1'b1 || bus.res_data !== r.data || bus.cmd_ready !== 1'b0 ||
                alu_a !== snap_a) begin
                n_fail++;
                $display("FAIL hold_%0d: valid=%b data=%h ready=%b a=%h want 1/%h/0/%h",
                         i, bus.res_valid, bus.res_data, bus.cmd_ready, alu_a, r.data, snap_a);
            end
        end
        bus.cmd_valid = 1'b0;
        bus.res_ready = 1'b1;
        @(negedge clk);
        n_checks++;
        if (bus.res_valid !== 1'b0 || bus.cmd_ready !== 1'b1) begin
            n_fail++; $display("FAIL hold_release: valid=%b ready=%b want 0/1",
                               bus.res_valid, bus.cmd_ready);
        end
        e = sb.pop_front();
        n_checks++;
        if (r !== e || r.data !== 16'd300) begin
            n_fail++; $display("FAIL hold_result: got %h want %h", r.data, e.data);
        end
    endtask

    task automatic test_acc_clr();
        int ac, rc;
        res_t r, e;
        logic seen;
        send_cmd(OPC_OR, 16'h1234, 16'h0000, 1'b0, 1'b0, 1'b0, ac);
        get_res(r, rc);
        e = sb.pop_front();
        n_checks++;
        if (r !== e || acc_out !== 16'h1234) begin
            n_fail++; $display("FAIL accset: data=%h acc=%h want 1234", r.data, acc_out);
        end
        send_cmd(OPC_ADDC, 16'h0001, 16'h0001, 1'b1, 1'b0, 1'b1, ac);
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (bus.res_valid !== 1'b0) seen = 1'b1;
            @(negedge clk);
        end
        n_checks++;
        if (seen || acc_out !== 16'h0000) begin
            n_fail++; $display("FAIL acc_clr: res_valid_seen=%b acc=%h want 0/0000", seen, acc_out);
        end
        send_cmd(OPC_ADDC, 16'hABCD, 16'h0001, 1'b0, 1'b1, 1'b0, ac);
        get_res(r, rc);
        e = sb.pop_front();
        n_checks++;
        if (r !== e || r.data !== 16'h0001) begin
            n_fail++; $display("FAIL acc_after_clr: got %h want 0001", r.data);
        end
    endtask

    task automatic test_back_to_back();
        int acc_cycs[6];
        fork
            begin
                for (int i = 0; i < 6; i++) begin
                    send_cmd(3'($urandom_range(0, 7)), 16'($urandom), 16'($urandom),
                             1'($urandom), 1'($urandom), 1'b0, acc_cycs[i]);
                end
            end
            begin
                res_t r, e;
                int rc;
                for (int i = 0; i < 6; i++) begin
                    get_res(r, rc);
                    n_checks++;
                    if (sb.size() == 0) begin
                        n_fail++; $display("FAIL b2b_%0d: got %h with empty scoreboard", i, r.data);
                    end else begin
                        e = sb.pop_front();
                        if (r !== e) begin
                            n_fail++; $display("FAIL b2b_%0d: got %h/%b/%b want %h/%b/%b",
                                               i, r.data, r.zer, r.neg, e.data, e.zer, e.neg);
                        end
                    end
                end
            end
        join
        for (int i = 1; i < 6; i++) begin
            n_checks++;
            if (acc_cycs[i] - acc_cycs[i-1] !== 3) begin
                n_fail++; $display("FAIL b2b_interval_%0d: got %0d want 3",
                                   i, acc_cycs[i] - acc_cycs[i-1]);
            end
        end
    endtask

    task automatic test_reset_exec();
        int ac, n;
        logic seen;
        // Full operation on the slow instance first: latency 1+4 and 3*0x1111.
        bus4.cmd_opc = OPC_B3; bus4.cmd_a = '0; bus4.cmd_b = 16'h1111; bus4.cmd_c = 1'b0;
        bus4.cmd_use_acc = 1'b0; bus4.cmd_acc_clr = 1'b0; bus4.cmd_valid = 1'b1;
        ac = cyc;
        @(negedge clk);
        bus4.cmd_valid = 1'b0;
        n = 0;
        while (bus4.res_valid !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        n_checks++;
        if (cyc - ac !== 5 || bus4.res_data !== 16'h3333) begin
            n_fail++; $display("FAIL settle4: latency=%0d data=%h want 5/3333", cyc - ac, bus4.res_data);
        end
        @(negedge clk);
`ifdef ALU_CMD_SEQ_STATS_EN
        n_checks++;
        if (stat_ops4 !== 16'd1) begin
            n_fail++; $display("FAIL stat_ops_count: got %0d want 1", stat_ops4);
        end
`endif
        bus4.cmd_opc = OPC_ADDC; bus4.cmd_a = 16'd7; bus4.cmd_b = 16'd8; bus4.cmd_valid = 1'b1;
        @(negedge clk);
        bus4.cmd_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        model_acc = '0;
        @(negedge clk);
        n_checks++;
        if (bus4.cmd_ready !== 1'b0 || bus4.res_valid !== 1'b0 || acc_out4 !== '0) begin
            n_fail++; $display("FAIL rst_exec: ready=%b valid=%b acc=%h want 0/0/0000",
                               bus4.cmd_ready, bus4.res_valid, acc_out4);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (bus4.cmd_ready !== 1'b1) begin
            n_fail++; $display("FAIL rst_exec_ready: got %b want 1", bus4.cmd_ready);
        end
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (bus4.res_valid !== 1'b0) seen = 1'b1;
            @(negedge clk);
        end
        n_checks++;
        if (seen || acc_out4 !== '0) begin
            n_fail++; $display("FAIL rst_exec_abort: res_valid_seen=%b acc=%h want 0/0000", seen, acc_out4);
        end
`ifdef ALU_CMD_SEQ_STATS_EN
        n_checks++;
        if (stat_ops4 !== 16'd0) begin
            n_fail++; $display("FAIL stat_ops_reset: got %0d want 0", stat_ops4);
        end
`endif
    endtask

    initial begin
        bus.cmd_valid = 1'b0; bus.cmd_opc = '0; bus.cmd_a = '0; bus.cmd_b = '0; bus.cmd_c = 1'b0;
        bus.cmd_use_acc = 1'b0; bus.cmd_acc_clr = 1'b0; bus.res_ready = 1'b1;
        bus4.cmd_valid = 1'b0; bus4.cmd_opc = '0; bus4.cmd_a = '0; bus4.cmd_b = '0; bus4.cmd_c = 1'b0;
        bus4.cmd_use_acc = 1'b0; bus4.cmd_acc_clr = 1'b0; bus4.res_ready = 1'b1;
        test_reset();
        test_addc();
        test_chain();
        test_wrap();
        test_backpressure();
        test_acc_clr();
        test_back_to_back();
        test_reset_exec();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
